lsu_req_buffer: RTL and testbench

// - Request queue directly upstream of cache_level_top. Accepts load/store requests from the core LSU

---
 rtl/lsu_req_buffer.sv | 174 +++++++++++++++++
 tb/tb_lsu_req_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req_buffer.sv
// In-order load/store request buffer in front of cache_level_top; one request in flight at a time.
// Optional stall watchdog built when LSU_BUF_TIMEOUT_EN is defined.
module lsu_req_buffer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OP_WIDTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           address,
    output logic [OP_WIDTH-1:0]   lsu_operator,
    output logic [31:0]           write_data,
    output logic                  mem_enable,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                  err_timeout
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e state_q, state_d;

    logic [31:0]         addr_mem  [DEPTH];
    logic [OP_WIDTH-1:0] op_mem    [DEPTH];
    logic [31:0]         wdata_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          empty;
    logic          push, pop;

    logic [31:0]           addr_q, addr_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Ready depends only on state held in flops, never on a same-cycle pop.
    assign req_ready = rst & ~full_q;
    assign push      = req_valid & req_ready;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign wr_ptr_d  = wr_ptr_q + PW'(push);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);
    assign full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    assign occupancy = wr_ptr_q - rd_ptr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        mem_enable  = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StIssue;
                    addr_d  = addr_mem[rd_ptr_q[AW-1:0]];
                    op_d    = op_mem[rd_ptr_q[AW-1:0]];
                    wdata_d = wdata_mem[rd_ptr_q[AW-1:0]];
                end
            end
            StIssue: begin
                mem_enable = 1'b1;
                if (!stall) begin
                    pop         = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = read_data;
                    state_d     = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            addr_q      <= '0;
            op_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[AW-1:0]]  <= req_addr;
            op_mem[wr_ptr_q[AW-1:0]]    <= req_op;
            wdata_mem[wr_ptr_q[AW-1:0]] <= req_wdata;
        end
    end

    assign address      = addr_q;
    assign lsu_operator = op_q;
    assign write_data   = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

`ifdef LSU_BUF_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;

    // Saturating count of consecutive stalled issue cycles; the request is never aborted.
    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q == StIssue) begin
            if (!stall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
        if (to_cnt_d == TW'(TIMEOUT_CYCLES)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_req_buffer.sv
// Self-checking bench for lsu_req_buffer: directed scenarios plus randomized traffic against
// a queue-based model of the request/response stream.
module tb_lsu_req_buffer;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
`ifdef LSU_BUF_TIMEOUT_EN
    localparam logic TO_ON = 1'b1;
`else
    localparam logic TO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, mem_enable, stall, rsp_valid, err_timeout;
    logic [31:0] req_addr, req_wdata, address, write_data, read_data, rsp_data;
    logic [3:0]  req_op, lsu_operator;
    logic [2:0]  occupancy;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  op;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    int          model_occ, checks, errors, cyc, n_acc;
    logic        exp_rv, last_acc;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    lsu_req_buffer #(
        .DEPTH         (DEPTH),
        .DATA_WIDTH    (32),
        .OP_WIDTH      (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_wdata   (req_wdata),
        .address     (address),
        .lsu_operator(lsu_operator),
        .write_data  (write_data),
        .mem_enable  (mem_enable),
        .stall       (stall),
        .read_data   (read_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .occupancy   (occupancy),
        .err_timeout (err_timeout)
    );

    // Advance one clock and update the model from the handshakes seen just before the edge.
    task automatic tick();
        logic        acc, cmp;
        logic [31:0] rd;
        #1;
        acc = rst && req_valid && req_ready;
        cmp = rst && mem_enable && !stall;
        rd  = read_data;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            model_occ = 0;
            exp_rv    = 1'b0;
        end else begin
            if (cmp) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                model_occ--;
                exp_rd = rd;
            end
            if (acc) begin
                exp_q.push_back('{addr: req_addr, op: req_op, wdata: req_wdata});
                model_occ++;
                n_acc++;
            end
            exp_rv = cmp;
        end
        last_acc = acc;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; stall = 1'b0;
        req_addr = '0; req_op = '0; req_wdata = '0; read_data = '0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++; if ({mem_enable, rsp_valid, err_timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {mem_enable, rsp_valid, err_timeout}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if ({address, write_data} !== 64'h0) begin
            errors++; $display("FAIL reset_addr_wdata got %h want 0", {address, write_data}); end
        checks++; if (lsu_operator !== 4'h0) begin errors++; $display("FAIL reset_op got %h want 0", lsu_operator); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_single_load();
        req_valid = 1'b1; req_addr = 32'h100; req_op = 4'h1; req_wdata = '0;
        stall = 1'b0; read_data = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        checks++; if (last_acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", last_acc); end
        checks++; if ({occupancy, mem_enable} !== {3'd1, 1'b0}) begin
            errors++; $display("FAIL single_after_accept occ=%0d me=%b want occ=1 me=0", occupancy, mem_enable); end
        tick();
        checks++; if ({mem_enable, address, lsu_operator, occupancy} !== {1'b1, 32'h100, 4'h1, 3'd1}) begin
            errors++; $display("FAIL single_issue me=%b addr=%h op=%h occ=%0d want 1 100 1 1",
                               mem_enable, address, lsu_operator, occupancy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b want 0", rsp_valid); end
        tick();
        checks++; if ({rsp_valid, rsp_data, occupancy, mem_enable} !== {1'b1, 32'hDEADBEEF, 3'd0, 1'b0}) begin
            errors++; $display("FAIL single_rsp rv=%b data=%h occ=%0d me=%b want 1 deadbeef 0 0",
                               rsp_valid, rsp_data, occupancy, mem_enable); end
        tick();
        checks++; if ({rsp_valid, mem_enable} !== 2'b00) begin
            errors++; $display("FAIL single_after rv/me got %b want 00", {rsp_valid, mem_enable}); end
        tick();
    endtask

    task automatic test_miss();
        logic [31:0] a, wd, b, rd;
        a = $urandom; wd = $urandom; b = $urandom; rd = $urandom;
        req_valid = 1'b1; req_addr = a; req_op = 4'h2; req_wdata = wd; stall = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i <= 10; i++) begin
            checks++; if ({mem_enable, address, write_data, rsp_valid} !== {1'b1, a, wd, 1'b0}) begin
                errors++; $display("FAIL miss_hold cycle %0d me=%b addr=%h wd=%h rv=%b want 1 %h %h 0",
                                   i, mem_enable, address, write_data, rsp_valid, a, wd); end
            req_valid = (i == 3);
            req_addr  = b;
            if (i == 10) begin
                stall = 1'b0; read_data = rd;
            end
            tick();
        end
        req_valid = 1'b0;
        checks++; if ({rsp_valid, rsp_data, mem_enable} !== {1'b1, rd, 1'b0}) begin
            errors++; $display("FAIL miss_rsp rv=%b data=%h me=%b want 1 %h 0", rsp_valid, rsp_data, mem_enable, rd); end
        tick();
        checks++; if ({mem_enable, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL miss_gap me/rv got %b want 00", {mem_enable, rsp_valid}); end
        tick();
        checks++; if ({mem_enable, address} !== {1'b1, b}) begin
            errors++; $display("FAIL miss_next_issue me=%b addr=%h want 1 %h", mem_enable, address, b); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL miss_second_rsp got %b want 1", rsp_valid); end
        tick();
        tick();
    endtask

    task automatic test_fill();
        logic [31:0] key;
        int          k, last_cyc;
        key = 32'h5A5A_0000;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'h200 + 32'(i * 4); req_op = 4'(i); req_wdata = $urandom;
            tick();
            checks++; if (last_acc !== (i < 4)) begin
                errors++; $display("FAIL fill_accept push %0d got %b want %b", i, last_acc, (i < 4)); end
            checks++; if (occupancy !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
                errors++; $display("FAIL fill_occ push %0d got %0d", i, occupancy); end
            if (i == 3) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", req_ready); end
            end
        end
        req_valid = 1'b0; stall = 1'b0; k = 0; last_cyc = 0;
        for (int t = 0; t < 20; t++) begin
            read_data = address ^ key;
            tick();
            if (rsp_valid) begin
                checks++; if (k >= 4 || rsp_data !== ((32'h200 + 32'(k * 4)) ^ key)) begin
                    errors++; $display("FAIL fill_order rsp %0d got %h want %h", k, rsp_data, (32'h200 + 32'(k * 4)) ^ key); end
                if (k > 0) begin
                    checks++; if (cyc - last_cyc != 3) begin
                        errors++; $display("FAIL fill_spacing rsp %0d got %0d want 3", k, cyc - last_cyc); end
                end
                last_cyc = cyc;
                k++;
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL fill_rsp_count got %0d want 4", k); end
    endtask

    task automatic test_push_pop();
        stall = 1'b1; req_valid = 1'b1; req_op = 4'h3; req_wdata = $urandom;
        req_addr = 32'hA00;
        tick();
        req_addr = 32'hA04;
        tick();
        checks++; if ({occupancy, mem_enable} !== {3'd2, 1'b1}) begin
            errors++; $display("FAIL pp_setup occ=%0d me=%b want 2 1", occupancy, mem_enable); end
        req_addr = 32'hA08; stall = 1'b0; read_data = $urandom;
        tick();
        req_valid = 1'b0;
        checks++; if ({last_acc, occupancy, rsp_valid} !== {1'b1, 3'd2, 1'b1}) begin
            errors++; $display("FAIL pp_same_edge acc=%b occ=%0d rv=%b want 1 2 1", last_acc, occupancy, rsp_valid); end
        for (int t = 0; t < 12; t++) tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL pp_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_random(input int n);
        int budget, sent;
        budget = n * 12 + 40;
        sent   = 0;
        while (budget > 0 && !(sent == n && model_occ == 0 && !rsp_valid)) begin
            req_valid = (sent < n) && ($urandom_range(0, 1) == 1);
            req_addr  = $urandom; req_op = 4'($urandom); req_wdata = $urandom;
            stall     = ($urandom_range(0, 2) == 0);
            read_data = $urandom;
            tick();
            budget--;
            if (last_acc) sent++;
            checks++; if (occupancy !== 3'(model_occ)) begin
                errors++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", cyc, occupancy, model_occ); end
            checks++; if (rsp_valid !== exp_rv) begin
                errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b want %b", cyc, rsp_valid, exp_rv); end
            if (rsp_valid && exp_rv) begin
                checks++; if (rsp_data !== exp_rd) begin
                    errors++; $display("FAIL rnd_rsp_data cyc %0d got %h want %h", cyc, rsp_data, exp_rd); end
            end
            checks++; if (req_ready !== (model_occ < DEPTH)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, req_ready, model_occ < DEPTH); end
            if (mem_enable) begin
                checks++; if (exp_q.size() == 0 || {address, lsu_operator, write_data} !== exp_q[0]) begin
                    errors++; $display("FAIL rnd_issue cyc %0d got %h/%h/%h", cyc, address, lsu_operator, write_data); end
            end
            if (rsp_valid) begin
                checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rnd_gap cyc %0d got me=1 want 0", cyc); end
            end
        end
        req_valid = 1'b0; stall = 1'b0;
        checks++; if (budget == 0) begin errors++; $display("FAIL rnd_timeout sent %0d of %0d occ %0d", sent, n, model_occ); end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = $urandom; req_wdata = $urandom;
            tick();
        end
        req_valid = 1'b0;
        checks++; if ({occupancy, mem_enable} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL rstmid_setup occ=%0d me=%b want 3 1", occupancy, mem_enable); end
        rst = 1'b0; stall = 1'b0;
        tick();
        checks++; if ({mem_enable, occupancy, rsp_valid, req_ready} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rstmid_drop me=%b occ=%0d rv=%b rdy=%b want 0 0 0 0",
                               mem_enable, occupancy, rsp_valid, req_ready); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++; if ({rsp_valid, mem_enable} !== 2'b00) begin
                errors++; $display("FAIL rstmid_quiet cycle %0d got %b want 00", t, {rsp_valid, mem_enable}); end
        end
    endtask

    task automatic test_timeout();
        rst = 1'b0;
        tick();
        rst = 1'b1; stall = 1'b1; req_valid = 1'b1; req_addr = 32'hC00;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 1; i <= TMO; i++) begin
            tick();
            checks++; if (err_timeout !== ((i >= TMO) && TO_ON)) begin
                errors++; $display("FAIL timeout_rise stalled %0d got %b want %b", i, err_timeout, (i >= TMO) && TO_ON); end
        end
        checks++; if ({mem_enable, occupancy} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL timeout_no_abort me=%b occ=%0d want 1 1", mem_enable, occupancy); end
        stall = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (err_timeout !== TO_ON) begin
            errors++; $display("FAIL timeout_sticky got %b want %b", err_timeout, TO_ON); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_reset got %b want 0", err_timeout); end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; n_acc = 0; model_occ = 0;
        exp_rv = 1'b0; exp_rd = '0; last_acc = 1'b0;
        test_reset();
        test_single_load();
        test_miss();
        test_fill();
        test_push_pop();
        test_random(9);
        test_reset_mid();
        test_timeout();
        test_random(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
